// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the HH:MM:SS countdown timer.
// Optional feature macro used by the top: COUNTDOWN_AUTORELOAD_EN.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HR   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam int HR_MAX_DEFAULT = 23;
  localparam int MS_MAX_DEFAULT = 59;

  function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/hms_decrement.sv
// Combinational borrow-chain decrement of an HH:MM:SS triple.
// A time of 00:00:00 is held rather than wrapped; zero flags the result.
module hms_decrement
  import countdown_timer_pkg::*;
#(
  parameter int MS_MAX = MS_MAX_DEFAULT
) (
  input  logic [5:0] hr,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [5:0] hr_next,
  output logic [5:0] min_next,
  output logic [5:0] sec_next,
  output logic       zero
);

  localparam logic [5:0] MS_TOP = 6'(MS_MAX);

  always_comb begin
    hr_next  = hr;
    min_next = min;
    sec_next = sec;
    if (sec != 6'd0) begin
      sec_next = sec - 6'd1;
    end else if (min != 6'd0) begin
      min_next = min - 6'd1;
      sec_next = MS_TOP;
    end else if (hr != 6'd0) begin
      hr_next  = hr - 6'd1;
      min_next = MS_TOP;
      sec_next = MS_TOP;
    end
    zero = (hr_next == 6'd0) && (min_next == 6'd0) && (sec_next == 6'd0);
  end

endmodule

// File: rtl/countdown_timer.sv
// Down-counting HH:MM:SS timer with load clamping and an IDLE/RUN/PAUSED/DONE FSM.
// Define COUNTDOWN_AUTORELOAD_EN to reload from the last loaded time on expiry.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int HR_MAX = HR_MAX_DEFAULT,
  parameter int MS_MAX = MS_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       preset,
  input  logic       tick,
  input  logic       load,
  input  logic [1:0] sel,
  input  logic [5:0] value,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       done
);

  localparam logic [5:0] HR_TOP = 6'(HR_MAX);
  localparam logic [5:0] MS_TOP = 6'(MS_MAX);

  // Control: tick/start/pause are one-clk pulses, load is a level; all are
  // sampled on every rising clk edge, with priority load > pause > start > tick.
  state_t     state, state_next;
  logic [5:0] hr_d, min_d, sec_d;
  logic       running_d, done_d;
  logic [5:0] dec_hr, dec_min, dec_sec;
  logic       dec_zero;
  logic       load_hit;
  logic       time_zero;
  logic       reload_pulse;

  assign load_hit  = load && (sel != SEL_NONE) && (state != ST_RUN);
  assign time_zero = (hr == 6'd0) && (min == 6'd0) && (sec == 6'd0);

  hms_decrement #(.MS_MAX(MS_MAX)) u_dec (
    .hr       (hr),
    .min      (min),
    .sec      (sec),
    .hr_next  (dec_hr),
    .min_next (dec_min),
    .sec_next (dec_sec),
    .zero     (dec_zero)
  );

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [5:0] sh_hr, sh_min, sh_sec;
  logic       sh_zero;

  assign sh_zero = (sh_hr == 6'd0) && (sh_min == 6'd0) && (sh_sec == 6'd0);

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      sh_hr  <= 6'd0;
      sh_min <= 6'd0;
      sh_sec <= 6'd0;
    end else if (load_hit) begin
      case (sel)
        SEL_SEC: sh_sec <= clamp6(value, MS_TOP);
        SEL_MIN: sh_min <= clamp6(value, MS_TOP);
        default: sh_hr  <= clamp6(value, HR_TOP);
      endcase
    end
  end
`endif

  always_comb begin
    state_next   = state;
    hr_d         = hr;
    min_d        = min;
    sec_d        = sec;
    reload_pulse = 1'b0;
    if (load_hit) begin
      case (sel)
        SEL_SEC: sec_d = clamp6(value, MS_TOP);
        SEL_MIN: min_d = clamp6(value, MS_TOP);
        default: hr_d  = clamp6(value, HR_TOP);
      endcase
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start && !time_zero) state_next = ST_RUN;
        ST_RUN: begin
          if (pause) begin
            state_next = ST_PAUSED;
          end else if (tick) begin
            hr_d  = dec_hr;
            min_d = dec_min;
            sec_d = dec_sec;
            if (dec_zero) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
              if (!sh_zero) begin
                hr_d         = sh_hr;
                min_d        = sh_min;
                sec_d        = sh_sec;
                reload_pulse = 1'b1;
              end else begin
                state_next = ST_DONE;
              end
`else
              state_next = ST_DONE;
`endif
            end
          end
        end
        ST_PAUSED: if (start) state_next = ST_RUN;
        default: ;
      endcase
    end
    running_d = (state_next == ST_RUN);
    done_d    = (state_next == ST_DONE) || reload_pulse;
  end

  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state   <= ST_IDLE;
      hr      <= 6'd0;
      min     <= 6'd0;
      sec     <= 6'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      hr      <= hr_d;
      min     <= min_d;
      sec     <= sec_d;
      running <= running_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; expectations are hand-computed.
// Inputs change on the falling edge, outputs are checked on the following falling edge.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       preset = 1'b1;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [1:0] sel = 2'd3;
  logic [5:0] value = 6'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] hr, min, sec;
  logic       running, done;

  int n_checks = 0;
  int n_errors = 0;

  countdown_timer dut (
    .clk     (clk),
    .preset  (preset),
    .tick    (tick),
    .load    (load),
    .sel     (sel),
    .value   (value),
    .start   (start),
    .pause   (pause),
    .hr      (hr),
    .min     (min),
    .sec     (sec),
    .running (running),
    .done    (done)
  );

  always #10 clk = ~clk;

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  // Driver tasks: assert on a falling edge, release on the next one.
  task automatic do_load(input logic [1:0] s, input logic [5:0] v);
    @(negedge clk);
    load = 1'b1; sel = s; value = v;
    @(negedge clk);
    load = 1'b0; sel = 2'd3;
  endtask

  task automatic pulse(input bit t, input bit st, input bit p);
    @(negedge clk);
    tick = t; start = st; pause = p;
    @(negedge clk);
    tick = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  task automatic load_hms(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    pulse(0, 0, 1);
    do_load(2'd2, h);
    do_load(2'd1, m);
    do_load(2'd0, s);
  endtask

  task automatic test_reset();
    #5;
    n_checks++;
    if ({hr, min, sec} !== hms(0, 0, 0)) begin
      n_errors++; $display("FAIL reset_time got %h exp %h", {hr, min, sec}, hms(0, 0, 0));
    end
    n_checks++;
    if (running !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags got run=%b done=%b exp 0 0", running, done);
    end
    @(negedge clk);
    preset = 1'b0;
  endtask

  task automatic test_countdown();
    logic [17:0] exp_t [3];
    exp_t[0] = hms(1, 0, 1);
    exp_t[1] = hms(1, 0, 0);
    exp_t[2] = hms(0, 59, 59);
    do_load(2'd2, 6'd1);
    n_checks++;
    if (hr !== 6'd1) begin
      n_errors++; $display("FAIL load_hr got %0d exp 1", hr);
    end
    do_load(2'd1, 6'd0);
    do_load(2'd0, 6'd2);
    n_checks++;
    if ({hr, min, sec} !== hms(1, 0, 2) || running !== 1'b0) begin
      n_errors++; $display("FAIL load_all got %h run=%b exp %h run=0", {hr, min, sec}, running, hms(1, 0, 2));
    end
    pulse(0, 1, 0);
    n_checks++;
    if (running !== 1'b1 || {hr, min, sec} !== hms(1, 0, 2)) begin
      n_errors++; $display("FAIL start got %h run=%b exp %h run=1", {hr, min, sec}, running, hms(1, 0, 2));
    end
    for (int i = 0; i < 3; i++) begin
      pulse(1, 0, 0);
      n_checks++;
      if ({hr, min, sec} !== exp_t[i] || running !== 1'b1) begin
        n_errors++; $display("FAIL tick%0d got %h run=%b exp %h run=1", i, {hr, min, sec}, running, exp_t[i]);
      end
    end
  endtask

  task automatic test_done();
    load_hms(6'd0, 6'd0, 6'd2);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    n_checks++;
    if ({hr, min, sec} !== hms(0, 0, 1) || done !== 1'b0) begin
      n_errors++; $display("FAIL done_pre got %h done=%b exp %h done=0", {hr, min, sec}, done, hms(0, 0, 1));
    end
    pulse(1, 0, 0);
    n_checks++;
    if ({hr, min, sec} !== hms(0, 0, 0) || done !== 1'b1 || running !== 1'b0) begin
      n_errors++; $display("FAIL done_hit got %h done=%b run=%b exp 0 done=1 run=0", {hr, min, sec}, done, running);
    end
    pulse(1, 1, 0);
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    n_checks++;
    if ({hr, min, sec} !== hms(0, 0, 0) || done !== 1'b1 || running !== 1'b0) begin
      n_errors++; $display("FAIL done_hold got %h done=%b run=%b exp 0 done=1 run=0", {hr, min, sec}, done, running);
    end
  endtask

  task automatic test_autoreload();
    load_hms(6'd0, 6'd0, 6'd2);
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    n_checks++;
    if ({hr, min, sec} !== hms(0, 0, 2) || done !== 1'b1 || running !== 1'b1) begin
      n_errors++; $display("FAIL reload got %h done=%b run=%b exp %h done=1 run=1", {hr, min, sec}, done, running, hms(0, 0, 2));
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++; $display("FAIL reload_pulse got done=%b exp 0", done);
    end
    pulse(1, 0, 0);
    n_checks++;
    if ({hr, min, sec} !== hms(0, 0, 1)) begin
      n_errors++; $display("FAIL reload_next got %h exp %h", {hr, min, sec}, hms(0, 0, 1));
    end
  endtask

  task automatic test_clamp();
    load_hms(6'd63, 6'd63, 6'd63);
    n_checks++;
    if ({hr, min, sec} !== hms(23, 59, 59) || done !== 1'b0) begin
      n_errors++; $display("FAIL clamp got %h done=%b exp %h done=0", {hr, min, sec}, done, hms(23, 59, 59));
    end
    pulse(0, 1, 0);
    do_load(2'd0, 6'd5);
    n_checks++;
    if ({hr, min, sec} !== hms(23, 59, 59) || running !== 1'b1) begin
      n_errors++; $display("FAIL load_in_run got %h run=%b exp %h run=1", {hr, min, sec}, running, hms(23, 59, 59));
    end
    pulse(0, 0, 1);
    do_load(2'd3, 6'd5);
    n_checks++;
    if ({hr, min, sec} !== hms(23, 59, 59) || running !== 1'b0) begin
      n_errors++; $display("FAIL sel_none got %h run=%b exp %h run=0", {hr, min, sec}, running, hms(23, 59, 59));
    end
    pulse(0, 1, 0);
    n_checks++;
    if (running !== 1'b1) begin
      n_errors++; $display("FAIL resume_after_sel_none got run=%b exp 1", running);
    end
  endtask

  task automatic test_pause();
    load_hms(6'd0, 6'd5, 6'd0);
    pulse(0, 1, 0);
    pulse(1, 0, 1);
    n_checks++;
    if (running !== 1'b0 || {hr, min, sec} !== hms(0, 5, 0)) begin
      n_errors++; $display("FAIL pause got %h run=%b exp %h run=0", {hr, min, sec}, running, hms(0, 5, 0));
    end
    for (int i = 0; i < 4; i++) pulse(1, 0, 0);
    n_checks++;
    if ({hr, min, sec} !== hms(0, 5, 0)) begin
      n_errors++; $display("FAIL paused_ticks got %h exp %h", {hr, min, sec}, hms(0, 5, 0));
    end
    pulse(1, 1, 0);
    n_checks++;
    if (running !== 1'b1 || {hr, min, sec} !== hms(0, 5, 0)) begin
      n_errors++; $display("FAIL start_with_tick got %h run=%b exp %h run=1", {hr, min, sec}, running, hms(0, 5, 0));
    end
    pulse(1, 0, 0);
    n_checks++;
    if ({hr, min, sec} !== hms(0, 4, 59)) begin
      n_errors++; $display("FAIL borrow_min got %h exp %h", {hr, min, sec}, hms(0, 4, 59));
    end
  endtask

  task automatic test_preset();
    load_hms(6'd12, 6'd34, 6'd56);
    pulse(0, 1, 0);
    n_checks++;
    if (running !== 1'b1 || {hr, min, sec} !== hms(12, 34, 56)) begin
      n_errors++; $display("FAIL preset_setup got %h run=%b exp %h run=1", {hr, min, sec}, running, hms(12, 34, 56));
    end
    @(negedge clk);
    #5 preset = 1'b1;
    #1;
    n_checks++;
    if ({hr, min, sec} !== hms(0, 0, 0) || running !== 1'b0 || done !== 1'b0) begin
      n_errors++; $display("FAIL preset_async got %h run=%b done=%b exp 0 0 0", {hr, min, sec}, running, done);
    end
    @(negedge clk);
    preset = 1'b0;
    pulse(0, 1, 0);
    n_checks++;
    if (running !== 1'b0 || {hr, min, sec} !== hms(0, 0, 0)) begin
      n_errors++; $display("FAIL start_zero got %h run=%b exp 0 run=0", {hr, min, sec}, running);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
`ifdef COUNTDOWN_AUTORELOAD_EN
    test_autoreload();
`else
    test_done();
`endif
    test_clamp();
    test_pause();
    test_preset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Down-counting HH:MM:SS timer, the counterpart of the board's up-counting 24-hour clock. Operator loads hours, minutes and seconds from the switch bank, starts the count, and the block decrements once per 1 Hz tick until 00:00:00, then raises `done`. Outputs feed the existing six-digit 7-segment display path (digit split and segment decode stay outside this block).

## Interface
Parameters:
- `HR_MAX`, default 23: largest loadable hour value.
- `MS_MAX`, default 59: largest loadable minute/second value.

Ports:
- `clk`  in  1  system clock, 50 MHz domain.
- `preset`  in  1  reset preset, asynchronous, active-high; clock clk.
- `tick`  in  1  one-`clk`-wide pulse at 1 Hz, from the existing divider.
- `load`  in  1  load `value` into the field chosen by `sel` (level, sampled every `clk`).
- `sel`  in  2  field select: 0 = sec, 1 = min, 2 = hr, 3 = no field (load ignored).
- `value`  in  6  load value, unsigned.
- `start`  in  1  start/resume pulse.
- `pause`  in  1  pause pulse.
- `hr`  out  6  remaining hours.
- `min`  out  6  remaining minutes.
- `sec`  out  6  remaining seconds.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset: state IDLE; `hr`/`min`/`sec` = 0; `running` = 0; `done` = 0.
- Load: accepted in IDLE, PAUSED, DONE; ignored in RUN. Value above field max clamps to max (hr to `HR_MAX`, min/sec to `MS_MAX`). Load in PAUSED or DONE moves to IDLE (clears `done`).
- IDLE: `start` with nonzero time goes to RUN; `start` with 00:00:00 is ignored.
- RUN: on `tick`, decrement with borrow: sec>0 → sec−1; else min>0 → min−1, sec=`MS_MAX`; else hr−1, min=sec=`MS_MAX`. If the result is 00:00:00, go to DONE in the same update. `pause` goes to PAUSED.
- PAUSED: count frozen; `start` returns to RUN (time nonzero by construction).
- DONE: time holds 00:00:00; `done` held high until `load` or `preset`. `start` and `pause` ignored.
- Priority within one cycle: `load` > `pause` > `start` > `tick`. `start` and `tick` in the same cycle: transition to RUN, that tick is not applied. `pause` and `tick` in RUN: pause wins, no decrement.
- All arithmetic is 6-bit unsigned; no field ever holds a value above its max, and no underflow is possible.
- `preset` mid-count: immediate return to reset values, independent of `clk`.

## Timing
- All outputs registered; no combinational input-to-output path.
- `load` sampled on edge N → field visible after edge N.
- `tick` sampled on edge N in RUN → new time and, if zero, `done` visible after edge N (latency 1 `clk`).
- `start` on edge N → `running` high after edge N; first decrement on the next `tick` strictly after N.
- `preset` assertion clears outputs asynchronously; release synchronous to next `clk` edge is the system's responsibility.

## Configuration
- `COUNTDOWN_AUTORELOAD_EN` defined: block keeps a shadow copy of the last loaded hr/min/sec. On reaching 00:00:00 in RUN, time reloads from the shadow on the same edge, state stays RUN, and `done` pulses high for exactly one `clk`. If the shadow is 00:00:00, behaviour is as without the macro. DONE is then entered only in that case.
- Not defined: no shadow registers; behaviour as in Operation (stop in DONE, `done` level).

## Structure
- Shared package: state enumeration (IDLE, RUN, PAUSED, DONE), `sel` encodings, default `HR_MAX`/`MS_MAX` constants.
- One sub-module `hms_decrement`: combinational borrow-chain decrement of (hr, min, sec), outputs the next time plus a `zero` flag. The top level holds the FSM, load clamping, and (optionally) the shadow registers.

## Test plan
- Reset then load sel=2 value=1, sel=1 value=0, sel=0 value=2; start; 3 ticks → 01:00:01, 01:00:00, 00:59:59; `running`=1.
- Load 00:00:02, start, 2 ticks → 00:00:00 with `done`=1 and `running`=0 after the second tick edge; further ticks and `start` → no change.
- Load value=63 on each field → reads 23:59:59; `load` asserted during RUN → time unchanged.
- RUN at 00:05:00: `pause`, 4 ticks → still 00:05:00; `start` together with a tick → RUN, still 00:05:00; next tick → 00:04:59.
- Assert `preset` mid-count at 12:34:56 between `clk` edges → outputs 0, `running`=0 immediately; `start` without a load → stays IDLE.
- With `COUNTDOWN_AUTORELOAD_EN`: load 00:00:02, start, 2 ticks → `done` high for one `clk`, time 00:00:02, `running`=1; next tick → 00:00:01.
